// File: rtl/sram_stack_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sram_stack_ctrl                                                            |
// | Push/pop stack controller driving an asynchronous SRAM with CE/OE/WE.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sram_stack_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 17,
  parameter int DEPTH    = 131072,
  parameter int WR_PULSE = 2,
  parameter int RD_WAIT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              error,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] input_data,
  input  logic [DATA_W-1:0] stackData
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_w_setup = 3'd1;
  localparam logic [2:0] c_st_w_pulse = 3'd2;
  localparam logic [2:0] c_st_w_hold  = 3'd3;
  localparam logic [2:0] c_st_r_setup = 3'd4;
  localparam logic [2:0] c_st_r_wait  = 3'd5;
  localparam logic [2:0] c_st_r_hold  = 3'd6;

  localparam int c_cnt_max = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  localparam logic [c_cnt_w-1:0] c_wr_last = c_cnt_w'(WR_PULSE - 1);
  localparam logic [c_cnt_w-1:0] c_rd_last = c_cnt_w'(RD_WAIT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [ADDR_W:0]    c_depth   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]    c_sp_one  = (ADDR_W + 1)'(1);

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [ADDR_W:0]    r_sp;
  logic [ADDR_W:0]    w_sp_dec;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_dout;
  logic               r_error;
  logic               w_idle;
  logic               w_full;
  logic               w_empty;
  logic               w_illegal;
  logic               w_accept_push;
  logic               w_accept_pop;
  logic               w_rd_sample;

  assign w_idle        = (r_state == c_st_idle);
  assign w_full        = (r_sp == c_depth);
  assign w_empty       = (r_sp == '0);
  assign w_sp_dec      = r_sp - c_sp_one;
  assign w_illegal     = w_idle & ((push & pop) | (push & w_full) | (pop & w_empty));
  assign w_accept_push = w_idle & push & ~pop & ~w_full;
  assign w_accept_pop  = w_idle & pop & ~push & ~w_empty;
  assign w_rd_sample   = (r_state == c_st_r_wait) && (r_cnt == c_rd_last);

  // State register and datapath; strobes decode from r_state so reset drops them at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_sp    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_dout  <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= (w_next_state != r_state) ? '0 : r_cnt + c_cnt_one;
      r_error <= w_illegal;
      if (w_accept_push) begin
        r_addr  <= r_sp[ADDR_W-1:0];
        r_wdata <= din;
      end else if (w_accept_pop) begin
        r_addr <= w_sp_dec[ADDR_W-1:0];
      end
      if (r_state == c_st_w_hold) begin
        r_sp <= r_sp + c_sp_one;
      end else if (w_rd_sample) begin
        r_sp   <= w_sp_dec;
        r_dout <= stackData;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept_push)     w_next_state = c_st_w_setup;
        else if (w_accept_pop) w_next_state = c_st_r_setup;
      end
      c_st_w_setup: w_next_state = c_st_w_pulse;
      c_st_w_pulse: if (r_cnt == c_wr_last) w_next_state = c_st_w_hold;
      c_st_w_hold:  w_next_state = c_st_idle;
      c_st_r_setup: w_next_state = c_st_r_wait;
      c_st_r_wait:  if (r_cnt == c_rd_last) w_next_state = c_st_r_hold;
      c_st_r_hold:  w_next_state = c_st_idle;
      default:      w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    ready      = 1'b0;
    CE         = 1'b0;
    OE         = 1'b1;
    WE         = 1'b1;
    dout_valid = 1'b0;
    case (r_state)
      c_st_idle:    begin ready = 1'b1; CE = 1'b1; end
      c_st_w_pulse: WE = 1'b0;
      c_st_r_wait:  OE = 1'b0;
      c_st_r_hold:  dout_valid = 1'b1;
      default:      ;
    endcase
  end

  assign full       = w_full;
  assign empty      = w_empty;
  assign error      = r_error;
  assign dout       = r_dout;
  assign address    = r_addr;
  assign input_data = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_stack_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sram_stack_ctrl                                                         |
// | Scoreboard bench with an SRAM behavioral model and a software stack model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sram_stack_ctrl;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 17;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              ready, dout_valid, full, empty, error, CE, OE, WE;
  logic [DATA_W-1:0] dout, input_data, stackData;
  logic [ADDR_W-1:0] address;

  always #5 clk = ~clk;

  sram_stack_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                    .WR_PULSE(2), .RD_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din),
    .ready(ready), .dout(dout), .dout_valid(dout_valid), .full(full),
    .empty(empty), .error(error), .CE(CE), .OE(OE), .WE(WE),
    .address(address), .input_data(input_data), .stackData(stackData)
  );

  // SRAM behavioral model: write on the rising edge of WE, read while CE/OE low
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  always @(posedge WE) if (!CE) mem[address] = input_data;
  always @* begin
    stackData = '0;
    if (!CE && !OE && mem.exists(address)) stackData = mem[address];
  end

  typedef struct packed {logic is_err; logic [DATA_W-1:0] data;} exp_t;
  exp_t              sb[$];
  exp_t              mon_e;
  logic [DATA_W-1:0] model[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc, ce_lo, we_lo, oe_lo, ce_first, we_first, bus_bad;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_wdata = '0;
  logic              exp_write = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic clear_counters();
    cyc = 0; ce_lo = 0; we_lo = 0; oe_lo = 0;
    ce_first = -1; we_first = -1; bus_bad = 0;
  endtask

  // Monitor: pops the scoreboard on every dout_valid / error pulse
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (!CE) begin
        ce_lo++;
        if (ce_first < 0) ce_first = cyc;
        if (address !== exp_addr || (exp_write && input_data !== exp_wdata)) bus_bad++;
      end
      if (!WE) begin
        we_lo++;
        if (we_first < 0) we_first = cyc;
      end
      if (!OE) oe_lo++;
      if (!OE && !WE) begin
        vectors++; miscompares++;
        $display("FAIL oe_we_overlap: got OE=0 WE=0, required not both low");
      end
      if (dout_valid || error) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_event: got dout_valid=%0b error=%0b, required none", dout_valid, error);
        end else begin
          mon_e = sb.pop_front();
          check("event_is_error", {31'd0, error}, {31'd0, mon_e.is_err});
          if (!mon_e.is_err) check("popped_word", {16'd0, dout}, {16'd0, mon_e.data});
        end
      end
    end
  end

  task automatic issue(input logic p, input logic q, input logic [DATA_W-1:0] d);
    bit ok;
    @(negedge clk);
    #1;
    ok = (p ^ q) && !(p && model.size() == DEPTH) && !(q && model.size() == 0);
    if (!ok) begin
      sb.push_back(exp_t'({1'b1, 16'h0000}));
    end else if (p) begin
      exp_addr  = ADDR_W'(model.size());
      exp_wdata = d;
      exp_write = 1'b1;
      model.push_back(d);
    end else begin
      exp_addr  = ADDR_W'(model.size() - 1);
      exp_write = 1'b0;
      sb.push_back(exp_t'({1'b0, model[$]}));
      void'(model.pop_back());
    end
    push = p; pop = q; din = d;
    @(posedge clk);
    #1 push = 1'b0; pop = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ready) break;
    end
    if (!ready) begin
      vectors++; miscompares++;
      $display("FAIL ready_timeout: got ready=0, required ready=1 within 20 cycles");
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model.delete();
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    clear_counters();
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", {29'd0, CE, OE, WE}, 32'h7);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_strobes_after", {29'd0, CE, OE, WE}, 32'h7);
    check("rst_address", {15'd0, address}, 32'h0);
    check("rst_input_data", {16'd0, input_data}, 32'h0);
    check("rst_dout", {16'd0, dout}, 32'h0);
    check("rst_pulses", {30'd0, dout_valid, error}, 32'h0);
    check("rst_status", {29'd0, ready, empty, full}, 32'h6);
    clear_counters();
    repeat (10) @(negedge clk);
    #1;
    check("idle_strobe_cycles", ce_lo + we_lo + oe_lo, 0);

    // Single push
    clear_counters();
    issue(1'b1, 1'b0, 16'h0001);
    check("push_ce_cycles", ce_lo, 4);
    check("push_we_cycles", we_lo, 2);
    check("push_oe_cycles", oe_lo, 0);
    check("push_we_offset", we_first - ce_first, 1);
    check("push_bus_stable", bus_bad, 0);
    check("push_status", {30'd0, empty, full}, 32'h0);
    check("push_mem0", {16'd0, mem[17'd0]}, 32'h0001);

    // Push then pop
    do_reset();
    issue(1'b1, 1'b0, 16'hA5A5);
    issue(1'b1, 1'b0, 16'h1234);
    clear_counters();
    issue(1'b0, 1'b1, 16'h0000);
    check("pop_addr_bus", bus_bad, 0);
    check("pop_oe_cycles", oe_lo, 2);
    check("pop_ce_cycles", ce_lo, 4);
    check("pop_we_cycles", we_lo, 0);
    issue(1'b0, 1'b1, 16'h0000);
    check("pop2_empty", {31'd0, empty}, 32'h1);
    check("dout_hold", {16'd0, dout}, 32'hA5A5);

    // Illegal requests
    clear_counters();
    issue(1'b0, 1'b1, 16'h0000);
    issue(1'b1, 1'b1, 16'h0007);
    check("illegal_strobes", ce_lo + we_lo + oe_lo, 0);
    check("illegal_empty", {31'd0, empty}, 32'h1);

    // Full boundary
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b1, 1'b0, DATA_W'(16'h0010 + i));
      check("fill_full", {31'd0, full}, (i == DEPTH - 1) ? 32'h1 : 32'h0);
    end
    clear_counters();
    issue(1'b1, 1'b0, 16'hBEEF);
    check("overflow_we_cycles", we_lo, 0);
    check("overflow_full", {31'd0, full}, 32'h1);
    for (int i = 0; i < DEPTH; i++) issue(1'b0, 1'b1, 16'h0000);
    check("drain_status", {30'd0, empty, full}, 32'h2);

    // Reset mid-write
    clear_counters();
    @(negedge clk);
    #1;
    exp_addr = '0; exp_wdata = 16'h5555; exp_write = 1'b1;
    push = 1'b1; din = 16'h5555;
    @(posedge clk);
    #1 push = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!WE) break;
    end
    check("midwrite_we_low", {31'd0, WE}, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("midwrite_strobes", {29'd0, CE, OE, WE}, 32'h7);
    model.delete();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midwrite_status", {29'd0, ready, empty, full}, 32'h6);
    check("midwrite_address", {15'd0, address}, 32'h0);
    issue(1'b1, 1'b0, 16'h0077);
    issue(1'b0, 1'b1, 16'h0000);

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1);
  end
endmodule
`default_nettype wire
